// File: rtl/mem_arbiter.sv
// mem_arbiter: shares the single byte-wide RAM port between instruction fetch
// and the load/store buffer. One request is owned at a time. It is broken into
// byte accesses at addr, addr+1, ... Read bytes are assembled little-endian.
// Completion is signalled with a one-cycle strobe to the owner.
module mem_arbiter #(
    parameter int                    ADDR_WIDTH   = 32,
    parameter logic [ADDR_WIDTH-1:0] IO_ADDR_BASE = ADDR_WIDTH'(32'h30000)
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [7:0]            mem_din,
    output logic [7:0]            mem_dout,
    output logic [ADDR_WIDTH-1:0] mem_a,
    output logic                  mem_wr,
    input  logic                  io_buffer_full,
    input  logic                  refresh_in,
    input  logic                  if_req_in,
    input  logic [ADDR_WIDTH-1:0] if_addr_in,
    output logic                  if_rdy_out,
    output logic [31:0]           if_inst_out,
    input  logic                  lsb_req_in,
    input  logic                  lsb_wr_in,
    input  logic [1:0]            lsb_size_in,
    input  logic [ADDR_WIDTH-1:0] lsb_addr_in,
    input  logic [31:0]           lsb_data_in,
    output logic                  lsb_done_out,
    output logic [31:0]           lsb_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_IF_RD = 2'd1,
        ST_LS_RD = 2'd2,
        ST_LS_WR = 2'd3
    } state_t;

    state_t                  state_reg;
    logic [1:0]              cnt_reg;      // index of the byte currently on the bus
    logic [1:0]              last_reg;     // index of the final byte (size - 1)
    logic [ADDR_WIDTH-1:0]   addr_reg;     // base address of the owned access
    logic [31:0]             wdata_reg;    // store data of the owned access
    logic [31:0]             rbuf_reg;     // read bytes captured so far
    logic                    io_reg;       // owned store targets the IO region

    logic                    cool_down;
    logic                    accept_lsb;
    logic                    accept_if;
    logic [1:0]              req_last;
    logic                    req_io;
    logic [1:0]              cnt_inc;
    logic [1:0]              issue_idx;
    logic [7:0]              wr_byte;
    logic                    io_stall;
    logic [31:0]             rbuf_merged;

    // Acceptance, size decode and the byte selected for the next store issue.
    always_comb begin
        // A strobe still showing means the owner has not yet seen completion;
        // give it that cycle to drop its request before anything is accepted.
        cool_down  = if_rdy_out | lsb_done_out;
        accept_lsb = lsb_req_in & ~cool_down & ~refresh_in;
        accept_if  = if_req_in & ~lsb_req_in & ~cool_down & ~refresh_in;
        case (lsb_size_in)
            2'd0:    req_last = 2'd0;
            2'd1:    req_last = 2'd1;
            default: req_last = 2'd3;   // size 3 is treated as a word
        endcase
        req_io    = (lsb_addr_in >= IO_ADDR_BASE);
        cnt_inc   = cnt_reg + 2'd1;
        // While a byte is on the bus the next issue is the following byte;
        // while stalled the pending byte is still cnt_reg.
        issue_idx = mem_wr ? cnt_inc : cnt_reg;
        wr_byte   = wdata_reg[{issue_idx, 3'b000} +: 8];
        io_stall  = io_reg & io_buffer_full;
    end

    // Drop the incoming RAM byte into its little-endian lane of the read buffer.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_lane
            assign rbuf_merged[8*gi +: 8] = (cnt_reg == 2'(gi)) ? mem_din : rbuf_reg[8*gi +: 8];
        end
    endgenerate

    // Request ownership, byte sequencing and registered bus/strobe outputs.
    always_ff @(posedge clk_in or posedge rst_in) begin
        if (rst_in) begin
            state_reg    <= ST_IDLE;
            cnt_reg      <= 2'd0;
            last_reg     <= 2'd0;
            addr_reg     <= '0;
            wdata_reg    <= 32'd0;
            rbuf_reg     <= 32'd0;
            io_reg       <= 1'b0;
            mem_a        <= '0;
            mem_dout     <= 8'd0;
            mem_wr       <= 1'b0;
            if_rdy_out   <= 1'b0;
            if_inst_out  <= 32'd0;
            lsb_done_out <= 1'b0;
            lsb_data_out <= 32'd0;
        end else if (rdy_in) begin
            // Strobes last exactly one enabled cycle.
            if_rdy_out   <= 1'b0;
            lsb_done_out <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    mem_wr <= 1'b0;
                    if (accept_lsb) begin
                        addr_reg  <= lsb_addr_in;
                        wdata_reg <= lsb_data_in;
                        last_reg  <= req_last;
                        io_reg    <= req_io;
                        cnt_reg   <= 2'd0;
                        rbuf_reg  <= 32'd0;    // unused upper load bytes read back as 0
                        mem_a     <= lsb_addr_in;
                        if (lsb_wr_in) begin
                            state_reg <= ST_LS_WR;
                            mem_dout  <= lsb_data_in[7:0];
                            mem_wr    <= ~(req_io & io_buffer_full);
                        end else begin
                            state_reg <= ST_LS_RD;
                        end
                    end else if (accept_if) begin
                        addr_reg  <= if_addr_in;
                        last_reg  <= 2'd3;
                        io_reg    <= 1'b0;
                        cnt_reg   <= 2'd0;
                        rbuf_reg  <= 32'd0;
                        mem_a     <= if_addr_in;
                        state_reg <= ST_IF_RD;
                    end
                end

                ST_IF_RD, ST_LS_RD: begin
                    if (refresh_in) begin
                        // Flushed read: abandon silently, no strobe.
                        state_reg <= ST_IDLE;
                        mem_wr    <= 1'b0;
                    end else begin
                        rbuf_reg <= rbuf_merged;
                        if (cnt_reg == last_reg) begin
                            state_reg <= ST_IDLE;
                            if (state_reg == ST_IF_RD) begin
                                if_rdy_out  <= 1'b1;
                                if_inst_out <= rbuf_merged;
                            end else begin
                                lsb_done_out <= 1'b1;
                                lsb_data_out <= rbuf_merged;
                            end
                        end else begin
                            cnt_reg <= cnt_inc;
                            mem_a   <= addr_reg + ADDR_WIDTH'(cnt_inc);
                        end
                    end
                end

                ST_LS_WR: begin
                    // Stores are already committed, so a flush does not stop them.
                    if (mem_wr && (cnt_reg == last_reg)) begin
                        state_reg    <= ST_IDLE;
                        mem_wr       <= 1'b0;
                        lsb_done_out <= 1'b1;
                    end else begin
                        if (mem_wr) begin
                            cnt_reg <= cnt_inc;
                        end
                        if (io_stall) begin
                            mem_wr <= 1'b0;
                        end else begin
                            mem_wr   <= 1'b1;
                            mem_a    <= addr_reg + ADDR_WIDTH'(issue_idx);
                            mem_dout <= wr_byte;
                        end
                    end
                end

                default: begin
                    state_reg <= ST_IDLE;
                    mem_wr    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus randomized traffic, checked every
// cycle against a transaction-level model of the arbiter and a byte RAM.
module tb_mem_arbiter;

    logic        clk_in = 1'b0;
    logic        rst_in = 1'b1;
    logic        rdy_in = 1'b1;
    logic [7:0]  mem_din = 8'd0;
    logic [7:0]  mem_dout;
    logic [31:0] mem_a;
    logic        mem_wr;
    logic        io_buffer_full = 1'b0;
    logic        refresh_in = 1'b0;
    logic        if_req_in = 1'b0;
    logic [31:0] if_addr_in = 32'd0;
    logic        if_rdy_out;
    logic [31:0] if_inst_out;
    logic        lsb_req_in = 1'b0;
    logic        lsb_wr_in = 1'b0;
    logic [1:0]  lsb_size_in = 2'd0;
    logic [31:0] lsb_addr_in = 32'd0;
    logic [31:0] lsb_data_in = 32'd0;
    logic        lsb_done_out;
    logic [31:0] lsb_data_out;

    always #5 clk_in = ~clk_in;

    mem_arbiter #(.ADDR_WIDTH(32), .IO_ADDR_BASE(32'h30000)) dut (
        .clk_in(clk_in), .rst_in(rst_in), .rdy_in(rdy_in),
        .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
        .io_buffer_full(io_buffer_full), .refresh_in(refresh_in),
        .if_req_in(if_req_in), .if_addr_in(if_addr_in),
        .if_rdy_out(if_rdy_out), .if_inst_out(if_inst_out),
        .lsb_req_in(lsb_req_in), .lsb_wr_in(lsb_wr_in), .lsb_size_in(lsb_size_in),
        .lsb_addr_in(lsb_addr_in), .lsb_data_in(lsb_data_in),
        .lsb_done_out(lsb_done_out), .lsb_data_out(lsb_data_out)
    );

    int n_checks = 0;
    int n_errors = 0;
    int if_strobes = 0;
    int lsb_strobes = 0;
    int wr_cycles = 0;

    // Byte RAM: unwritten locations return an address-derived pattern.
    logic [7:0] ram [logic [31:0]];

    function automatic logic [7:0] rd(input logic [31:0] a);
        if (ram.exists(a)) return ram[a];
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Transaction-level model: kind 0 fetch, 1 load, 2 store.
    bit          m_busy;
    int          m_kind, m_n, m_k, m_sent;
    logic [31:0] m_addr, m_data, m_result;
    bit          m_io;
    logic        e_wr, e_if_rdy, e_lsb_done;
    logic [31:0] e_a, e_inst, e_ldata;
    logic [7:0]  e_dout;

    task automatic model_reset();
        m_busy = 0; m_kind = 0; m_n = 0; m_k = 0; m_sent = 0;
        m_addr = 0; m_data = 0; m_result = 0; m_io = 0;
        e_wr = 0; e_if_rdy = 0; e_lsb_done = 0;
        e_a = 0; e_inst = 0; e_ldata = 0; e_dout = 0;
    endtask

    task automatic model_step();
        bit cool;
        if (rst_in) begin
            model_reset();
            return;
        end
        if (!rdy_in) return;
        cool = e_if_rdy || e_lsb_done;
        e_if_rdy = 0;
        e_lsb_done = 0;
        if (!m_busy) begin
            e_wr = 0;
            if (!cool && !refresh_in && (lsb_req_in || if_req_in)) begin
                m_busy = 1; m_k = 0; m_sent = 0;
                if (lsb_req_in) begin
                    m_kind = lsb_wr_in ? 2 : 1;
                    m_addr = lsb_addr_in;
                    m_data = lsb_data_in;
                    m_n = (lsb_size_in == 2'd0) ? 1 : (lsb_size_in == 2'd1) ? 2 : 4;
                end else begin
                    m_kind = 0;
                    m_addr = if_addr_in;
                    m_n = 4;
                end
                m_io = (m_addr >= 32'h30000);
                if (m_kind == 2) begin
                    if (!(m_io && io_buffer_full)) begin
                        e_wr = 1; e_a = m_addr; e_dout = m_data[7:0];
                    end
                end else begin
                    m_result = 0;
                    for (int i = 0; i < m_n; i++)
                        m_result |= 32'(rd(m_addr + 32'(i))) << (8 * i);
                    e_a = m_addr;
                end
            end
        end else if (m_kind == 2) begin
            if (e_wr) m_sent++;
            if (m_sent == m_n) begin
                m_busy = 0; e_wr = 0; e_lsb_done = 1;
            end else if (m_io && io_buffer_full) begin
                e_wr = 0;
            end else begin
                e_wr = 1;
                e_a = m_addr + 32'(m_sent);
                e_dout = m_data[8*m_sent +: 8];
            end
        end else if (refresh_in) begin
            m_busy = 0; e_wr = 0;
        end else begin
            m_k++;
            if (m_k == m_n) begin
                m_busy = 0;
                if (m_kind == 0) begin e_if_rdy = 1; e_inst = m_result; end
                else begin e_lsb_done = 1; e_ldata = m_result; end
            end else begin
                e_a = m_addr + 32'(m_k);
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        chk("mem_wr", 32'(mem_wr), 32'(e_wr));
        if ((m_busy && m_kind != 2) || e_wr) chk("mem_a", mem_a, e_a);
        if (e_wr) chk("mem_dout", 32'(mem_dout), 32'(e_dout));
        chk("if_rdy_out", 32'(if_rdy_out), 32'(e_if_rdy));
        chk("lsb_done_out", 32'(lsb_done_out), 32'(e_lsb_done));
        chk("if_inst_out", if_inst_out, e_inst);
        chk("lsb_data_out", lsb_data_out, e_ldata);
    endtask

    // RAM and requester behaviour seen from the bus during the current cycle.
    task automatic bus_side();
        if (mem_wr === 1'b1) begin
            ram[mem_a] = mem_dout;
            wr_cycles++;
        end
        mem_din = rd(mem_a);
        if (if_rdy_out === 1'b1) begin if_req_in = 0; if_strobes++; end
        if (lsb_done_out === 1'b1) begin lsb_req_in = 0; lsb_strobes++; end
    endtask

    task automatic tick();
        @(posedge clk_in);
        model_step();
        @(negedge clk_in);
        compare_all();
        bus_side();
    endtask

    // which: 0 = fetch strobe, 1 = load/store strobe; ticks = -1 on timeout.
    task automatic run_until(input int which, input int limit, output int ticks);
        ticks = 0;
        while (ticks < limit) begin
            tick();
            ticks++;
            if ((which == 0) ? (if_rdy_out === 1'b1) : (lsb_done_out === 1'b1)) return;
        end
        ticks = -1;
    endtask

    task automatic async_reset();
        if_req_in = 0;
        lsb_req_in = 0;
        #2 rst_in = 1'b1;
        #1;
        model_reset();
        chk("rst_mem_a", mem_a, 32'd0);
        chk("rst_mem_wr", 32'(mem_wr), 32'd0);
        chk("rst_mem_dout", 32'(mem_dout), 32'd0);
        chk("rst_if_rdy", 32'(if_rdy_out), 32'd0);
        chk("rst_if_inst", if_inst_out, 32'd0);
        chk("rst_lsb_done", 32'(lsb_done_out), 32'd0);
        chk("rst_lsb_data", lsb_data_out, 32'd0);
        tick();
        rst_in = 1'b0;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: got no finish, expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int t;
        logic [31:0] ra;
        model_reset();
        repeat (2) tick();
        chk("reset_mem_a", mem_a, 32'd0);
        chk("reset_mem_wr", 32'(mem_wr), 32'd0);
        chk("reset_if_inst", if_inst_out, 32'd0);
        chk("reset_lsb_data", lsb_data_out, 32'd0);
        rst_in = 1'b0;
        tick();

        // Fetch at 0x1000.
        ram[32'h1000] = 8'h13; ram[32'h1001] = 8'h05;
        ram[32'h1002] = 8'hA0; ram[32'h1003] = 8'h00;
        if_strobes = 0; wr_cycles = 0;
        if_addr_in = 32'h1000; if_req_in = 1;
        run_until(0, 20, t);
        chk("fetch_latency", t, 5);
        chk("fetch_inst", if_inst_out, 32'h00A00513);
        chk("model_fetch_inst", e_inst, 32'h00A00513);
        repeat (3) tick();
        chk("fetch_strobes", if_strobes, 1);
        chk("fetch_no_write", wr_cycles, 0);

        // Simultaneous load half and fetch: load wins, fetch accepted at E0+4.
        ram[32'h2002] = 8'h34; ram[32'h2003] = 8'h12;
        lsb_wr_in = 0; lsb_size_in = 2'd1; lsb_addr_in = 32'h2002; lsb_req_in = 1;
        if_addr_in = 32'h1000; if_req_in = 1;
        run_until(1, 20, t);
        chk("load_first_latency", t, 3);
        chk("load_half_data", lsb_data_out, 32'h00001234);
        chk("model_load_data", e_ldata, 32'h00001234);
        tick();
        chk("fetch_not_early", mem_a, 32'h2003);
        tick();
        chk("fetch_accept_addr", mem_a, 32'h1000);
        run_until(0, 20, t);
        chk("fetch_after_load", t, 4);
        repeat (3) tick();

        // Store word.
        wr_cycles = 0; lsb_strobes = 0;
        lsb_wr_in = 1; lsb_size_in = 2'd2; lsb_addr_in = 32'h400; lsb_data_in = 32'hDEADBEEF;
        lsb_req_in = 1;
        run_until(1, 20, t);
        chk("store_latency", t, 5);
        chk("store_wr_cycles", wr_cycles, 4);
        chk("store_b0", 32'(rd(32'h400)), 32'hEF);
        chk("store_b1", 32'(rd(32'h401)), 32'hBE);
        chk("store_b2", 32'(rd(32'h402)), 32'hAD);
        chk("store_b3", 32'(rd(32'h403)), 32'hDE);
        repeat (3) tick();
        chk("store_strobes", lsb_strobes, 1);

        // IO store stalled by a full IO buffer.
        wr_cycles = 0;
        io_buffer_full = 1;
        lsb_wr_in = 1; lsb_size_in = 2'd0; lsb_addr_in = 32'h30000; lsb_data_in = 32'h41;
        lsb_req_in = 1;
        repeat (3) tick();
        chk("io_stall_no_write", wr_cycles, 0);
        io_buffer_full = 0;
        tick();
        chk("io_write_issued", 32'(mem_wr), 32'd1);
        chk("io_write_addr", mem_a, 32'h30000);
        run_until(1, 10, t);
        chk("io_done_latency", t, 1);
        chk("io_ram_byte", 32'(rd(32'h30000)), 32'h41);
        repeat (3) tick();

        // Flush right after a fetch is accepted.
        if_addr_in = 32'h1000; if_req_in = 1;
        tick();
        refresh_in = 1; if_req_in = 0; if_strobes = 0; wr_cycles = 0;
        tick();
        refresh_in = 0;
        repeat (8) tick();
        chk("flush_fetch_no_strobe", if_strobes, 0);
        chk("flush_fetch_no_write", wr_cycles, 0);

        // Same flush during a store: all bytes land and done pulses.
        lsb_wr_in = 1; lsb_size_in = 2'd2; lsb_addr_in = 32'h500; lsb_data_in = 32'h11223344;
        lsb_req_in = 1;
        tick();
        refresh_in = 1;
        tick();
        refresh_in = 0;
        run_until(1, 20, t);
        chk("flush_store_latency", t, 3);
        chk("flush_store_b0", 32'(rd(32'h500)), 32'h44);
        chk("flush_store_b3", 32'(rd(32'h503)), 32'h11);
        repeat (3) tick();

        // Reset mid-load, then a fetch paused by rdy_in.
        lsb_wr_in = 0; lsb_size_in = 2'd2; lsb_addr_in = 32'h1000; lsb_req_in = 1;
        tick(); tick();
        async_reset();
        lsb_strobes = 0;
        repeat (6) tick();
        chk("reset_load_no_strobe", lsb_strobes, 0);
        if_strobes = 0;
        if_addr_in = 32'h1000; if_req_in = 1;
        tick(); tick();
        rdy_in = 0;
        tick(); tick();
        rdy_in = 1;
        run_until(0, 20, t);
        chk("paused_fetch_latency", t, 3);
        chk("paused_fetch_inst", if_inst_out, 32'h00A00513);
        repeat (3) tick();
        chk("paused_fetch_strobes", if_strobes, 1);

        // Randomized traffic.
        for (int c = 0; c < 4000; c++) begin
            rdy_in = ($urandom_range(0, 9) != 0);
            io_buffer_full = ($urandom_range(0, 9) < 3);
            refresh_in = ($urandom_range(0, 24) == 0);
            if (!if_req_in && $urandom_range(0, 3) == 0) begin
                if_addr_in = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFE : 32'($urandom_range(0, 16'h3FFF));
                if_req_in = 1;
            end
            if (!lsb_req_in && $urandom_range(0, 3) == 0) begin
                case ($urandom_range(0, 3))
                    0:       ra = 32'h30000 + 32'($urandom_range(0, 15));
                    1:       ra = 32'hFFFF_FFFD;
                    default: ra = 32'($urandom_range(0, 16'h3FFF));
                endcase
                lsb_addr_in = ra;
                lsb_wr_in = 1'($urandom_range(0, 1));
                lsb_size_in = 2'($urandom_range(0, 3));
                lsb_data_in = $urandom();
                lsb_req_in = 1;
            end
            if ($urandom_range(0, 799) == 0) async_reset();
            else tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
